// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the MIPS funct codes the unit reacts to, the FSM state enum,
// the operation-type enum and small funct classification helpers.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } muldiv_op_t;

  function automatic logic is_muldiv_fn(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  // Any funct that touches HI/LO; only these can stall the pipeline.
  function automatic logic is_hilo_fn(input logic [5:0] f);
    return is_muldiv_fn(f) || (f == FN_MFHI) || (f == FN_MTHI) ||
           (f == FN_MFLO) || (f == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle between the ID/EX operand register and the multiply/divide unit.
//   Req_in/Func_in/A_in/B_in : request from the pipeline
//   Stall_out                : hold the ID/EX register this cycle
//   Busy_out/Done_out        : mul/div in flight / HI,LO just updated
//   O_out/Valid_out          : MFHI/MFLO result and its qualifier
interface muldiv_if;
  logic        Req_in;
  logic [5:0]  Func_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        Stall_out;
  logic        Busy_out;
  logic        Done_out;
  logic [31:0] O_out;
  logic        Valid_out;

  modport master (
    output Req_in, Func_in, A_in, B_in,
    input  Stall_out, Busy_out, Done_out, O_out, Valid_out
  );

  modport slave (
    input  Req_in, Func_in, A_in, B_in,
    output Stall_out, Busy_out, Done_out, O_out, Valid_out
  );
endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath shared by multiply and divide.
//   clk, rst      : clock, synchronous active-high reset (counter only)
//   load          : latch operand magnitudes and clear the counter
//   step_en       : perform one iteration this cycle
//   is_div        : iteration kind (restoring divide vs shift-add multiply)
//   a_mag, b_mag  : operand magnitudes captured on load
//   hi_res/lo_res : product {hi,lo}, or remainder (hi) / quotient (lo)
//   dvs_zero      : latched divisor is zero
//   last_step     : the step taken this cycle is the 32nd
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step_en,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        dvs_zero,
  output logic        last_step
);

  // acc: upper product half / partial remainder
  // quo: multiplier being consumed / quotient being built
  logic [31:0] acc_q, acc_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [32:0] sum;
  logic [32:0] rsh;
  logic [32:0] diff;

  always_comb begin
    acc_d = acc_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
    rsh   = {acc_q, quo_q[31]};
    // Partial remainder stays below the divisor, so rsh < 2*divisor and
    // bit 32 of the difference is a clean borrow flag.
    diff  = rsh - {1'b0, dvs_q};
    if (load) begin
      acc_d = '0;
      quo_d = a_mag;
      dvs_d = b_mag;
      cnt_d = '0;
    end else if (step_en) begin
      cnt_d = cnt_q + 5'd1;
      if (is_div) begin
        if (!diff[32]) begin
          acc_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          acc_d = rsh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end else begin
        // {acc,quo} is the 64-bit product register shifted right each step
        acc_d = sum[32:1];
        quo_d = {sum[0], quo_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
    acc_q <= acc_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign hi_res    = acc_q;
  assign lo_res    = quo_q;
  assign dvs_zero  = (dvs_q == 32'd0);
  assign last_step = step_en && (cnt_q == 5'd31);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, servicing
// MFHI/MFLO/MTHI/MTLO, stalling HI/LO instructions while an op is in flight.
//   ref_clk : clock, rising edge
//   reset   : synchronous active-high
//   bus     : request/response bundle (slave side)
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     ref_clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic          neg_res_q, neg_res_d;   // negate product / quotient
  logic          neg_rem_q, neg_rem_d;   // remainder takes sign of A
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   o_q, o_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic        hilo_fn, accept, start, signed_op;
  logic [31:0] a_mag, b_mag;
  logic [31:0] hi_res, lo_res;
  logic        dvs_zero, last_step;
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign hilo_fn   = is_hilo_fn(bus.Func_in);
  assign accept    = bus.Req_in && hilo_fn && (state_q == IDLE);
  assign start     = accept && is_muldiv_fn(bus.Func_in);
  assign signed_op = (bus.Func_in == FN_MULT) || (bus.Func_in == FN_DIV);
  assign a_mag     = (signed_op && bus.A_in[31]) ? -bus.A_in : bus.A_in;
  assign b_mag     = (signed_op && bus.B_in[31]) ? -bus.B_in : bus.B_in;

  muldiv_iter u_iter (
    .clk       (ref_clk),
    .rst       (reset),
    .load      (start),
    .step_en   (state_q == CALC),
    .is_div    (op_q == DIV),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .hi_res    (hi_res),
    .lo_res    (lo_res),
    .dvs_zero  (dvs_zero),
    .last_step (last_step)
  );

  assign prod_mag = {hi_res, lo_res};
  assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
  assign quo_fix  = neg_res_q ? -lo_res : lo_res;
  assign rem_fix  = neg_rem_q ? -hi_res : hi_res;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    o_d       = o_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          op_d      = ((bus.Func_in == FN_MULT) || (bus.Func_in == FN_MULTU)) ? MUL : DIV;
          neg_res_d = signed_op && (bus.A_in[31] ^ bus.B_in[31]);
          neg_rem_d = signed_op && bus.A_in[31];
        end
        if (accept) begin
          case (bus.Func_in)
            FN_MTHI: hi_d = bus.A_in;
            FN_MTLO: lo_d = bus.A_in;
            FN_MFHI: begin o_d = hi_q; valid_d = 1'b1; end
            FN_MFLO: begin o_d = lo_q; valid_d = 1'b1; end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (last_step) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == MUL) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dvs_zero) begin
          // With a zero divisor every trial subtract succeeds, so the
          // remainder register ends up holding the latched dividend.
          lo_d = 32'hFFFF_FFFF;
          hi_d = hi_res;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      o_q       <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      o_q       <= o_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.Stall_out = bus.Req_in && hilo_fn && (state_q != IDLE);
  assign bus.Busy_out  = (state_q != IDLE);
  assign bus.Done_out  = done_q;
  assign bus.O_out     = o_q;
  assign bus.Valid_out = valid_q;

endmodule
